// File: rtl/prf_ram_multiport_pkg.sv
// prf_pkg: shared types and helpers for the prf_ram_multiport register file.
//   prf_dbg_state_e : scrub/debug engine states
//   PRF_DBG_BYTE    : debug access granularity in bits
//   prf_parity()    : even-parity bit of a data word (zero-extended to PRF_MAX_WIDTH)
// Optional feature macro used by the slice: PRF_PARITY_EN.
package prf_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        COMMIT
    } prf_dbg_state_e;

    localparam int PRF_DBG_BYTE  = 8;
    localparam int PRF_MAX_WIDTH = 1024;

    // Zero extension leaves the parity unchanged, so callers cast up to PRF_MAX_WIDTH.
    function automatic logic prf_parity(input logic [PRF_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/prf_ram_multiport_if.sv
// prf_ram_multiport_if: functional read/write bus of the register file.
//   rdAddr_i : NUM_RD*INDEX  read addresses, port p at [p*INDEX+:INDEX]
//   rdData_o : NUM_RD*WIDTH  registered read data
//   wrAddr_i : NUM_WR*INDEX  write addresses
//   wrData_i : NUM_WR*WIDTH  write data
//   wrEn_i   : NUM_WR        per-port write enable
// master = issue/writeback side, slave = register file.
interface prf_ram_multiport_if #(
    parameter int NUM_RD = 8,
    parameter int NUM_WR = 4,
    parameter int INDEX  = 7,
    parameter int WIDTH  = 64
);
    logic [NUM_RD*INDEX-1:0] rdAddr_i;
    logic [NUM_RD*WIDTH-1:0] rdData_o;
    logic [NUM_WR*INDEX-1:0] wrAddr_i;
    logic [NUM_WR*WIDTH-1:0] wrData_i;
    logic [NUM_WR-1:0]       wrEn_i;

    modport master (
        output rdAddr_i, wrAddr_i, wrData_i, wrEn_i,
        input  rdData_o
    );

    modport slave (
        input  rdAddr_i, wrAddr_i, wrData_i, wrEn_i,
        output rdData_o
    );
endinterface

// File: rtl/prf_ram_multiport_dbg.sv
// prf_dbg_engine: post-reset scrub and byte-serial debug access engine.
//   clk, reset        : clock, asynchronous active-low reset
//   dbgAddr_i         : {entry, byte lane}
//   dbgWrData_i/WrEn_i: debug byte write into the staging word
//   dbgRdEn_i         : debug read request
//   dbgRdData_o/Valid : debug read byte and its one-cycle valid
//   dbgBusy_o         : high in INIT and COMMIT (strobes dropped)
//   initDone_o        : high once the scrub has finished
//   memRdAddr_o/Data_i: storage read used by debug reads
//   wrHit_i           : a functional write targets intWrAddr_o this cycle
//   intWrEn/Addr/Data : lowest-priority internal write port
// Optional feature macro of this slice: PRF_PARITY_EN (not used here).
module prf_dbg_engine
    import prf_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int INDEX = 7,
    parameter int WIDTH = 64
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [INDEX+$clog2(WIDTH/PRF_DBG_BYTE)-1:0]     dbgAddr_i,
    input  logic [PRF_DBG_BYTE-1:0]                         dbgWrData_i,
    input  logic                                            dbgWrEn_i,
    input  logic                                            dbgRdEn_i,
    output logic [PRF_DBG_BYTE-1:0]                         dbgRdData_o,
    output logic                                            dbgValid_o,
    output logic                                            dbgBusy_o,
    output logic                                            initDone_o,
    output logic [INDEX-1:0]                                memRdAddr_o,
    input  logic [WIDTH-1:0]                                memRdData_i,
    input  logic                                            wrHit_i,
    output logic                                            intWrEn_o,
    output logic [INDEX-1:0]                                intWrAddr_o,
    output logic [WIDTH-1:0]                                intWrData_o
);
    localparam int LANES  = WIDTH / PRF_DBG_BYTE;
    localparam int LANE_W = $clog2(LANES);

    prf_dbg_state_e    state_q, state_d;
    logic [INDEX-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  stg_q, stg_d;
    logic [INDEX-1:0]  ent_q, ent_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              valid_q, valid_d;

    logic [INDEX-1:0]  reqEnt;
    logic [LANE_W-1:0] reqLane;

    assign reqEnt      = dbgAddr_i[LANE_W +: INDEX];
    assign reqLane     = dbgAddr_i[LANE_W-1:0];
    assign memRdAddr_o = reqEnt;

    assign initDone_o  = (state_q != INIT);
    assign dbgBusy_o   = (state_q != IDLE);
    assign dbgValid_o  = valid_q;
    assign dbgRdData_o = word_q[lane_q*PRF_DBG_BYTE +: PRF_DBG_BYTE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            stg_q   <= '0;
            ent_q   <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            ent_q   <= ent_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stg_d       = stg_q;
        ent_d       = ent_q;
        word_d      = word_q;
        lane_d      = lane_q;
        valid_d     = 1'b0;
        intWrEn_o   = 1'b0;
        intWrAddr_o = ent_q;
        intWrData_o = stg_q;
        case (state_q)
            INIT: begin
                intWrEn_o   = 1'b1;
                intWrAddr_o = cnt_q;
                intWrData_o = '0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == INDEX'(DEPTH-1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // A write strobe takes precedence; a simultaneous read is dropped.
                if (dbgWrEn_i) begin
                    stg_d[reqLane*PRF_DBG_BYTE +: PRF_DBG_BYTE] = dbgWrData_i;
                    ent_d = reqEnt;
                    if (reqLane == LANE_W'(LANES-1)) begin
                        state_d = COMMIT;
                    end
                end else if (dbgRdEn_i) begin
                    word_d  = memRdData_i;
                    lane_d  = reqLane;
                    valid_d = 1'b1;
                end
            end
            COMMIT: begin
                // A functional write to the same entry owns this cycle; retry next.
                if (!wrHit_i) begin
                    intWrEn_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end
endmodule

// File: rtl/prf_ram_multiport.sv
// prf_ram_multiport: parametrised multi-port physical register file.
//   clk, reset    : clock, asynchronous active-low reset
//   bus (slave)   : functional reads (1-cycle registered) and writes
//   initDone_o    : high once the post-reset scrub is complete
//   dbgAddr_i     : {entry, byte lane} for debug accesses
//   dbgWrData_i, dbgWrEn_i, dbgRdEn_i : debug strobes
//   dbgRdData_o, dbgValid_o, dbgBusy_o: debug read byte, valid pulse, busy
//   parityErr_o   : per read port parity error (only with PRF_PARITY_EN)
// Write priority: internal engine port lowest, then functional port 0..NUM_WR-1.
module prf_ram_multiport
    import prf_pkg::*;
#(
    parameter int NUM_RD  = 8,
    parameter int NUM_WR  = 4,
    parameter int DEPTH   = 128,
    parameter int INDEX   = 7,
    parameter int WIDTH   = 64,
    parameter int FORWARD = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    prf_ram_multiport_if.slave                          bus,
    output logic                                        initDone_o,
    input  logic [INDEX+$clog2(WIDTH/PRF_DBG_BYTE)-1:0] dbgAddr_i,
    input  logic [PRF_DBG_BYTE-1:0]                     dbgWrData_i,
    input  logic                                        dbgWrEn_i,
    input  logic                                        dbgRdEn_i,
    output logic [PRF_DBG_BYTE-1:0]                     dbgRdData_o,
    output logic                                        dbgValid_o,
`ifdef PRF_PARITY_EN
    output logic [NUM_RD-1:0]                           parityErr_o,
`endif
    output logic                                        dbgBusy_o
);
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [NUM_RD*WIDTH-1:0] rdData_q, rdData_d;
    logic                    initDone;
    logic [INDEX-1:0]        dbgMemAddr;
    logic [WIDTH-1:0]        dbgMemData;
    logic                    wrHit;
    logic                    intWrEn;
    logic [INDEX-1:0]        intWrAddr;
    logic [WIDTH-1:0]        intWrData;

    prf_dbg_engine #(
        .DEPTH (DEPTH),
        .INDEX (INDEX),
        .WIDTH (WIDTH)
    ) u_dbg (
        .clk         (clk),
        .reset       (reset),
        .dbgAddr_i   (dbgAddr_i),
        .dbgWrData_i (dbgWrData_i),
        .dbgWrEn_i   (dbgWrEn_i),
        .dbgRdEn_i   (dbgRdEn_i),
        .dbgRdData_o (dbgRdData_o),
        .dbgValid_o  (dbgValid_o),
        .dbgBusy_o   (dbgBusy_o),
        .initDone_o  (initDone),
        .memRdAddr_o (dbgMemAddr),
        .memRdData_i (dbgMemData),
        .wrHit_i     (wrHit),
        .intWrEn_o   (intWrEn),
        .intWrAddr_o (intWrAddr),
        .intWrData_o (intWrData)
    );

    assign initDone_o   = initDone;
    assign dbgMemData   = mem_q[dbgMemAddr];
    assign bus.rdData_o = rdData_q;

    always_comb begin
        wrHit = 1'b0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (bus.wrEn_i[w] && bus.wrAddr_i[w*INDEX +: INDEX] == intWrAddr) begin
                wrHit = 1'b1;
            end
        end
    end

    // Later non-blocking writes override earlier ones: engine first, then ascending ports.
    always_ff @(posedge clk) begin
        if (intWrEn) begin
            mem_q[intWrAddr] <= intWrData;
        end
        if (initDone) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (bus.wrEn_i[w]) begin
                    mem_q[bus.wrAddr_i[w*INDEX +: INDEX]] <= bus.wrData_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef PRF_PARITY_EN
    logic              par_q [DEPTH];
    logic [NUM_RD-1:0] perr_q, perr_d;

    always_ff @(posedge clk) begin
        if (intWrEn) begin
            par_q[intWrAddr] <= prf_parity(PRF_MAX_WIDTH'(intWrData));
        end
        if (initDone) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (bus.wrEn_i[w]) begin
                    par_q[bus.wrAddr_i[w*INDEX +: INDEX]] <=
                        prf_parity(PRF_MAX_WIDTH'(bus.wrData_i[w*WIDTH +: WIDTH]));
                end
            end
        end
    end

    assign parityErr_o = perr_q;
`endif

    always_comb begin : rd_mux
        logic [INDEX-1:0] a;
        logic [WIDTH-1:0] v;
        logic             fwd;
        a        = '0;
        v        = '0;
        fwd      = 1'b0;
        rdData_d = '0;
`ifdef PRF_PARITY_EN
        perr_d   = '0;
`endif
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            a   = bus.rdAddr_i[p*INDEX +: INDEX];
            v   = mem_q[a];
            fwd = 1'b0;
            if (FORWARD != 0) begin
                // Ascending scan so the highest matching write port wins.
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (bus.wrEn_i[w] && bus.wrAddr_i[w*INDEX +: INDEX] == a) begin
                        v   = bus.wrData_i[w*WIDTH +: WIDTH];
                        fwd = 1'b1;
                    end
                end
            end
            if (initDone) begin
                rdData_d[p*WIDTH +: WIDTH] = v;
`ifdef PRF_PARITY_EN
                perr_d[p] = !fwd && (par_q[a] != prf_parity(PRF_MAX_WIDTH'(mem_q[a])));
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdData_q <= '0;
`ifdef PRF_PARITY_EN
            perr_q   <= '0;
`endif
        end else begin
            rdData_q <= rdData_d;
`ifdef PRF_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_prf_ram_multiport.sv
// Testbench for prf_ram_multiport: randomized and directed stimulus, an
// array-based reference model, and a scoreboard drained by a monitor process.
// Optional feature macro exercised when defined: PRF_PARITY_EN.
module tb_prf_ram_multiport;
    localparam int NUM_RD  = 8;
    localparam int NUM_WR  = 4;
    localparam int DEPTH   = 128;
    localparam int INDEX   = 7;
    localparam int WIDTH   = 64;
    localparam int FORWARD = 1;
    localparam int LANES   = WIDTH / 8;
    localparam int LANE_W  = 3;
    localparam int DAW     = INDEX + LANE_W;

    logic           clk = 1'b0;
    logic           reset;
    logic [DAW-1:0] dbgAddr;
    logic [7:0]     dbgWrData;
    logic           dbgWrEn;
    logic           dbgRdEn;
    logic [7:0]     dbgRdData;
    logic           dbgValid;
    logic           dbgBusy;
    logic           initDone;
`ifdef PRF_PARITY_EN
    logic [NUM_RD-1:0] parityErr;
`endif

    prf_ram_multiport_if #(
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .INDEX  (INDEX),
        .WIDTH  (WIDTH)
    ) bus ();

    prf_ram_multiport #(
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR),
        .DEPTH   (DEPTH),
        .INDEX   (INDEX),
        .WIDTH   (WIDTH),
        .FORWARD (FORWARD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .initDone_o  (initDone),
        .dbgAddr_i   (dbgAddr),
        .dbgWrData_i (dbgWrData),
        .dbgWrEn_i   (dbgWrEn),
        .dbgRdEn_i   (dbgRdEn),
        .dbgRdData_o (dbgRdData),
        .dbgValid_o  (dbgValid),
`ifdef PRF_PARITY_EN
        .parityErr_o (parityErr),
`endif
        .dbgBusy_o   (dbgBusy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned             due;
        logic [NUM_RD*WIDTH-1:0] rd;
        logic [NUM_RD-1:0]       perr;
        logic                    init;
        logic                    busy;
    } exp_t;

    typedef struct {
        int unsigned due;
        logic [7:0]  b;
    } dexp_t;

    exp_t  q[$];
    dexp_t dq[$];

    // Reference model state
    logic [WIDTH-1:0] mem_m [DEPTH];
    bit               bad_m [DEPTH];
    int unsigned      scrubbed;
    bit               commit_pend;
    logic [WIDTH-1:0] stg_m;
    int unsigned      ent_m;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.rdAddr_i = '0;
        bus.wrAddr_i = '0;
        bus.wrData_i = '0;
        bus.wrEn_i   = '0;
        dbgAddr      = '0;
        dbgWrData    = '0;
        dbgWrEn      = 1'b0;
        dbgRdEn      = 1'b0;
    endtask

    task automatic set_rd(input int unsigned p, input int unsigned a);
        bus.rdAddr_i[p*INDEX +: INDEX] = INDEX'(a);
    endtask

    task automatic set_wr(input int unsigned w, input int unsigned a, input logic [WIDTH-1:0] d);
        bus.wrEn_i[w]                  = 1'b1;
        bus.wrAddr_i[w*INDEX +: INDEX] = INDEX'(a);
        bus.wrData_i[w*WIDTH +: WIDTH] = d;
    endtask

    task automatic dbg_wr(input int unsigned e, input int unsigned l, input logic [7:0] b);
        dbgWrEn   = 1'b1;
        dbgAddr   = DAW'((e << LANE_W) | l);
        dbgWrData = b;
    endtask

    task automatic dbg_rd(input int unsigned e, input int unsigned l);
        dbgRdEn = 1'b1;
        dbgAddr = DAW'((e << LANE_W) | l);
    endtask

    task automatic rand_inputs(input int unsigned span);
        int unsigned r;
        clear_inputs();
        for (int unsigned p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(0, span-1));
        for (int unsigned w = 0; w < NUM_WR; w++)
            if ($urandom_range(0, 2) == 0)
                set_wr(w, $urandom_range(0, span-1), {$urandom, $urandom});
        r = $urandom_range(0, 15);
        if (r == 0 || r == 2) dbg_wr($urandom_range(0, span-1), $urandom_range(0, LANES-1), 8'($urandom));
        if (r == 1 || r == 2) dbg_rd($urandom_range(0, span-1), $urandom_range(0, LANES-1));
    endtask

    // Predict the effect of the next clock edge from the currently driven inputs,
    // queue the expected outputs, then let the edge happen.
    task automatic step();
        exp_t             e;
        logic [WIDTH-1:0] v, old_dbg;
        bit               fwd, hit, was_commit, scrub;
        int unsigned      a, ent, lane, wa;
        scrub  = (scrubbed < DEPTH);
        ent    = 32'(dbgAddr) >> LANE_W;
        lane   = 32'(dbgAddr) % LANES;
        e.due  = cyc + 1;
        e.rd   = '0;
        e.perr = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            a   = 32'(bus.rdAddr_i[p*INDEX +: INDEX]);
            v   = mem_m[a];
            fwd = 0;
            if (FORWARD != 0)
                for (int unsigned w = 0; w < NUM_WR; w++)
                    if (bus.wrEn_i[w] && 32'(bus.wrAddr_i[w*INDEX +: INDEX]) == a) begin
                        v   = bus.wrData_i[w*WIDTH +: WIDTH];
                        fwd = 1;
                    end
            if (!scrub) begin
                e.rd[p*WIDTH +: WIDTH] = v;
                e.perr[p]              = !fwd && bad_m[a];
            end
        end
        if (scrub) begin
            mem_m[scrubbed] = '0;
            bad_m[scrubbed] = 0;
            scrubbed++;
        end else begin
            old_dbg    = mem_m[ent];
            was_commit = commit_pend;
            if (was_commit) begin
                hit = 0;
                for (int unsigned w = 0; w < NUM_WR; w++)
                    if (bus.wrEn_i[w] && 32'(bus.wrAddr_i[w*INDEX +: INDEX]) == ent_m) hit = 1;
                if (!hit) begin
                    mem_m[ent_m] = stg_m;
                    bad_m[ent_m] = 0;
                    commit_pend  = 0;
                end
            end
            for (int unsigned w = 0; w < NUM_WR; w++)
                if (bus.wrEn_i[w]) begin
                    wa        = 32'(bus.wrAddr_i[w*INDEX +: INDEX]);
                    mem_m[wa] = bus.wrData_i[w*WIDTH +: WIDTH];
                    bad_m[wa] = 0;
                end
            if (!was_commit) begin
                if (dbgWrEn) begin
                    stg_m[lane*8 +: 8] = dbgWrData;
                    ent_m              = ent;
                    if (lane == LANES-1) commit_pend = 1;
                end else if (dbgRdEn) begin
                    dq.push_back('{due: cyc + 1, b: old_dbg[lane*8 +: 8]});
                end
            end
        end
        e.init = (scrubbed == DEPTH);
        e.busy = !e.init || commit_pend;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int unsigned p = 0; p < NUM_RD; p++)
            chk($sformatf("reset_rd%0d", p), bus.rdData_o[p*WIDTH +: WIDTH], '0);
        chk("reset_initDone", 64'(initDone), 64'(0));
        chk("reset_dbgBusy", 64'(dbgBusy), 64'(1));
        chk("reset_dbgValid", 64'(dbgValid), 64'(0));
        chk("reset_dbgRdData", 64'(dbgRdData), 64'(0));
`ifdef PRF_PARITY_EN
        chk("reset_parityErr", 64'(parityErr), 64'(0));
`endif
        scrubbed    = 0;
        commit_pend = 0;
        stg_m       = '0;
        ent_m       = 0;
        reset       = 1'b1;
    endtask

    // Monitor: drains the scoreboards one edge at a time, 1 time unit after the edge.
    initial begin : monitor
        exp_t  e;
        dexp_t d;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                for (int unsigned p = 0; p < NUM_RD; p++)
                    chk($sformatf("rd%0d@%0d", p, cyc), bus.rdData_o[p*WIDTH +: WIDTH], e.rd[p*WIDTH +: WIDTH]);
                chk($sformatf("initDone@%0d", cyc), 64'(initDone), 64'(e.init));
                chk($sformatf("dbgBusy@%0d", cyc), 64'(dbgBusy), 64'(e.busy));
`ifdef PRF_PARITY_EN
                chk($sformatf("parityErr@%0d", cyc), 64'(parityErr), 64'(e.perr));
`endif
            end
            if (dbgValid) begin
                if (dq.size() > 0 && dq[0].due == cyc) begin
                    d = dq.pop_front();
                    chk($sformatf("dbgRdData@%0d", cyc), 64'(dbgRdData), 64'(d.b));
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dbgValid@%0d: got 1 expected 0", cyc);
                end
            end else if (dq.size() > 0 && dq[0].due == cyc) begin
                d = dq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL dbgValid@%0d: got 0 expected 1", cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b0;
        clear_inputs();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 0;
        end
        @(negedge clk);
        do_reset();

        // Scrub window: writes and debug strobes must be ignored, reads return 0.
        for (int unsigned i = 0; i < DEPTH + 3; i++) begin
            rand_inputs(DEPTH);
            if (i == 5) set_wr(0, 42, 64'h1234_5678_9ABC_DEF0);
            if (i == 10) set_rd(0, 127);
            step();
        end
        clear_inputs(); set_rd(0, 42); set_rd(1, 127); step();

        // Forwarding and write-port priority
        clear_inputs(); set_wr(0, 9, 64'hDEAD_BEEF_0000_0001); set_rd(3, 9); step();
        clear_inputs(); set_rd(3, 9); step();
        clear_inputs(); set_wr(0, 20, 64'h11); set_wr(3, 20, 64'h33); step();
        clear_inputs(); set_rd(0, 20); step();

        // Debug write of entry 5, then functional and debug readback
        for (int unsigned l = 0; l < LANES; l++) begin
            clear_inputs(); dbg_wr(5, l, 8'(l + 1)); step();
        end
        clear_inputs(); step();
        clear_inputs(); set_rd(0, 5); step();
        clear_inputs(); dbg_rd(5, 2); step();
        clear_inputs(); step();

        // Commit colliding with a functional write to the same entry
        for (int unsigned l = 0; l < LANES; l++) begin
            clear_inputs(); dbg_wr(5, l, 8'(8'hA0 + l)); step();
        end
        clear_inputs(); set_wr(1, 5, 64'hAA); set_rd(2, 5); dbg_wr(6, 7, 8'h55); step();
        clear_inputs(); set_rd(2, 5); step();
        clear_inputs(); set_rd(2, 5); step();

`ifdef PRF_PARITY_EN
        clear_inputs(); set_wr(0, 7, 64'h0123_4567_89AB_CDEF); step();
        dut.mem_q[7][0] = ~dut.mem_q[7][0];
        mem_m[7][0]     = ~mem_m[7][0];
        bad_m[7]        = 1;
        clear_inputs(); set_rd(1, 7); step();
        clear_inputs(); set_wr(2, 7, 64'h5); set_rd(4, 7); step();
        clear_inputs(); set_rd(1, 7); step();
`endif

        // Randomized traffic on a narrow address window to provoke collisions
        for (int unsigned i = 0; i < 500; i++) begin
            rand_inputs(16);
            step();
        end

        // Reset while a commit is pending: commit is lost and the scrub restarts
        clear_inputs(); step();
        clear_inputs(); step();
        for (int unsigned l = 0; l < LANES; l++) begin
            clear_inputs(); dbg_wr(3, l, 8'hC0); step();
        end
        do_reset();
        for (int unsigned i = 0; i < DEPTH + 2; i++) begin
            rand_inputs(DEPTH);
            step();
        end
        clear_inputs(); dbg_wr(3, 7, 8'h7E); step();
        clear_inputs(); set_rd(5, 3); step();
        clear_inputs(); set_rd(5, 3); dbg_rd(3, 7); step();
        for (int unsigned i = 0; i < 50; i++) begin
            rand_inputs(8);
            step();
        end

        clear_inputs();
        repeat (3) @(negedge clk);
        if (q.size() != 0 || dq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q.size(), dq.size());
        end
        n_cmp++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prf_ram_multiport.md
Name: prf_ram_multiport

Overview:
- Parametrised physical register file storage: successor to the fixed per-width PRF instantiation.
- Read ports (NUM_RD), write ports (NUM_WR), depth and width are generic; no per-width ifdef port lists.
- Adds a registered read path with optional write-to-read forwarding, a post-reset scrub engine, and a byte-serial debug access engine with busy handshake.
- Sits in the register-read stage, fed by issue (reads) and writeback bypass packets (writes).

Parameters:
- NUM_RD, 8, number of read ports (2 x issue width).
- NUM_WR, 4, number of functional write ports.
- DEPTH, 128, number of physical registers.
- INDEX, 7, log2(DEPTH).
- WIDTH, 64, data bits per entry; must be a multiple of 8.
- FORWARD, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the old value.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rdAddr_i  in  NUM_RD*INDEX  read addresses, port p at [p*INDEX+:INDEX].
- rdData_o  out  NUM_RD*WIDTH  registered read data.
- wrAddr_i  in  NUM_WR*INDEX  write addresses.
- wrData_i  in  NUM_WR*WIDTH  write data.
- wrEn_i  in  NUM_WR  per-port write enable.
- initDone_o  out  1  high once the scrub is complete.
- dbgAddr_i  in  INDEX+log2(WIDTH/8)  {entry, byte lane}.
- dbgWrData_i  in  8  debug write byte.
- dbgWrEn_i  in  1  debug byte write strobe.
- dbgRdEn_i  in  1  debug read request.
- dbgRdData_o  out  8  debug read byte.
- dbgValid_o  out  1  dbgRdData_o valid.
- dbgBusy_o  out  1  debug engine cannot accept a strobe.

Behaviour:
- Reset (asserted low, asynchronous): rdData_o=0, initDone_o=0, dbgRdData_o=0, dbgValid_o=0, dbgBusy_o=1, staging word=0, FSM=INIT, scrub counter=0.
- INIT:
  - Writes zero to entry[scrub counter] each cycle; counter increments.
  - At counter==DEPTH-1, after that write: initDone_o=1, dbgBusy_o=0, next state IDLE. Scrub takes exactly DEPTH cycles after reset release.
  - Functional writes are ignored. Reads return 0. Debug strobes are ignored.
- Reads:
  - One-cycle latency: rdData_o(p) at edge t+1 = entry[rdAddr_i(p)] as sampled at edge t.
  - FORWARD=1: if any wrEn_i(w) matches the address in the same cycle, the forwarded data is returned. The highest matching w wins.
- Writes: all enabled ports commit at the clock edge. On a same-address collision, the highest port index wins.
- Debug write (IDLE):
  - A dbgWrEn_i byte is stored into staging[lane].
  - A write to lane WIDTH/8-1 moves the FSM to COMMIT with the latched entry index.
- COMMIT:
  - Writes the staging word to the entry, then returns to IDLE.
  - Any functional wrEn_i to the same entry in that cycle wins; the FSM stays in COMMIT and retries next cycle.
  - dbgBusy_o=1 while in COMMIT; strobes received in COMMIT are dropped.
- Debug read (IDLE): dbgRdEn_i latches entry[dbgAddr_i entry] into a read word. The next cycle gives dbgValid_o=1 for 1 cycle and dbgRdData_o = read word[lane], using the lane sampled with the request.
- Simultaneous dbgWrEn_i and dbgRdEn_i: the write is serviced and the read is dropped.
- Mid-operation reset: the FSM aborts, pending commits are lost, and the scrub restarts.

Optional Feature:
- PRF_PARITY_EN defined:
  - Each entry stores an extra even-parity bit, computed on every write path (functional, scrub, debug).
  - Adds output parityErr_o[NUM_RD], registered alongside rdData_o; it is high when the stored parity mismatches the stored data. Forwarded reads report 0.
  - parityErr_o resets to 0.
- Undefined: no parity storage and no parityErr_o port.

Decomposition:
- Shared package prf_pkg:
  - typedef prf_dbg_state_e {INIT, IDLE, COMMIT}.
  - Constant PRF_DBG_BYTE = 8.
  - Function prf_parity(data).
- Sub-module prf_dbg_engine: the scrub/debug FSM, staging and read word. It drives a single internal write port that the storage array treats as lowest priority.

Test Plan:
- Reset release, DEPTH=128 -> initDone_o rises exactly 128 cycles later; a read of entry 127 returns 0; a wrEn on cycle 5 has no effect.
- Write entry 9 = 0xDEAD_BEEF_0000_0001 on port 0; read 9 on port 3 in the same cycle -> rdData_o(3) = that value next cycle with FORWARD=1; the old value (0) with FORWARD=0.
- Ports 0 and 3 both write entry 20 (0x11, 0x33) -> a later read returns 0x33.
- Debug write bytes 0x01..0x08 to lanes 0..7 of entry 5 -> dbgBusy_o=1 for 1 cycle; a read of 5 returns 0x0807060504030201. Debug read of lane 2 -> dbgValid_o pulse with 0x03.
- COMMIT to entry 5 colliding with functional wrEn to 5 (0xAA) -> functional data lands, commit retries next cycle, final value is the staging word, dbgBusy_o high for 2 cycles.
- PRF_PARITY_EN: force-flip a stored bit of entry 7, then read 7 -> parityErr_o=1 with the read data; a fresh write clears the error.
